// File: rtl/fifo_buffer_vr.sv
// Valid/ready FIFO ahead of a round-robin arbiter port.
// Registered occupancy drives both handshake flags; head is read from the array.
module fifo_buffer_vr #(
  parameter int Width = 32,
  parameter int Depth = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [Width-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [Width-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(Depth+1)-1:0] count
);

  localparam int PW = $clog2(Depth);
  localparam int CW = $clog2(Depth+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(Depth);

  logic [Width-1:0] r_mem [Depth];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == DEPTH_C);
  assign w_empty = (r_count == '0);
  assign w_push  = in_valid && !w_full;
  assign w_pop   = out_ready && !w_empty;

  assign in_ready  = !w_full;
  assign out_valid = !w_empty;
  assign out_data  = r_mem[r_rptr];
  assign count     = r_count;

  // Storage write; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wptr] <= in_data;
    end
  end

  // Pointer advance; wrap happens by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
    end
  end

  // Occupancy tracking; simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  a_count_max : assert property (
    @(posedge clk) disable iff (rst) r_count <= DEPTH_C);

  a_head_stable : assert property (
    @(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> $stable(out_data));

  a_no_push_full : assert property (
    @(posedge clk) disable iff (rst) !(w_push && w_full));

endmodule

// File: tb/tb_fifo_buffer_vr.sv
// Randomized and directed bench for fifo_buffer_vr.
// A queue model tracks contents; literal checks pin directed scenarios.
module tb_fifo_buffer_vr;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 0;
  logic         rst = 1;
  logic         in_valid = 0;
  logic [W-1:0] in_data = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready = 0;
  logic [2:0]   count;

  int n_pass = 0;
  int n_total = 0;

  logic [W-1:0] q[$];
  bit           model_ok = 0;

  fifo_buffer_vr #(.Width(W), .Depth(D)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  // Reference model: contents as a queue, decisions from its own size.
  always @(posedge clk) begin : model
    int sz;
    sz = q.size();
    if (rst) begin
      q.delete();
      model_ok = 1;
    end else begin
      if (out_ready && sz != 0) void'(q.pop_front());
      if (in_valid && sz != D) q.push_back(in_data);
    end
  end

  // Compare DUT against the model every cycle, away from the edge.
  always @(negedge clk) begin
    if (model_ok && !rst) begin
      chk("count", 32'(count), 32'(q.size()));
      chk("in_ready", 32'(in_ready), 32'(q.size() != D));
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      if (q.size() != 0) chk("out_data", 32'(out_data), 32'(q[0]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] d);
    in_valid = 1;
    in_data = d;
    tick();
    in_valid = 0;
  endtask

  task automatic drain_expect(input logic [W-1:0] d, input string nm);
    out_ready = 1;
    chk(nm, 32'(out_data), 32'(d));
    tick();
    out_ready = 0;
  endtask

  initial begin
    logic [W-1:0] fill[4];
    fill[0] = 8'h11; fill[1] = 8'h22;
    fill[2] = 8'h33; fill[3] = 8'h44;

    // Reset / idle
    rst = 1;
    tick();
    tick();
    rst = 0;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_count", 32'(count), 0);
    tick();
    chk("idle_count", 32'(count), 0);

    // Fill then drain
    for (int i = 0; i < 4; i++) begin
      push(fill[i]);
      chk("fill_count", 32'(count), 32'(i + 1));
    end
    chk("full_ready", 32'(in_ready), 0);
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_data", 32'(out_data), 32'(fill[i]));
      tick();
    end
    out_ready = 0;
    chk("drain_count", 32'(count), 0);
    chk("drain_valid", 32'(out_valid), 0);

    // Simultaneous push/pop at count 2, wrapping pointers
    push(8'hA0);
    push(8'hA1);
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1;
      in_data = 8'(8'hA2 + i);
      chk("pp_data", 32'(out_data), 32'(8'hA0 + i));
      tick();
      chk("pp_count", 32'(count), 2);
    end
    in_valid = 0;
    out_ready = 0;
    drain_expect(8'hA3, "pp_tail0");
    drain_expect(8'hA4, "pp_tail1");

    // Full with pop: held beat enters the cycle after the pop
    for (int i = 0; i < 4; i++) push(8'(8'hB0 + i));
    in_valid = 1;
    in_data = 8'h55;
    out_ready = 1;
    chk("fp_notready", 32'(in_ready), 0);
    tick();
    out_ready = 0;
    chk("fp_count3", 32'(count), 3);
    chk("fp_ready", 32'(in_ready), 1);
    tick();
    in_valid = 0;
    chk("fp_count4", 32'(count), 4);
    drain_expect(8'hB1, "fp_d1");
    drain_expect(8'hB2, "fp_d2");
    drain_expect(8'hB3, "fp_d3");
    drain_expect(8'h55, "fp_d4");

    // Stall stability while pushes continue
    push(8'h3C);
    in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      in_data = 8'(8'hC0 + i);
      tick();
      chk("stall_data", 32'(out_data), 32'h3C);
      chk("stall_count", 32'(count), (i + 2 > 4) ? 4 : i + 2);
    end
    in_valid = 0;
    drain_expect(8'h3C, "stall_d0");
    drain_expect(8'hC0, "stall_d1");
    drain_expect(8'hC1, "stall_d2");
    drain_expect(8'hC2, "stall_d3");

    // Reset mid-operation overrides handshakes
    push(8'h61);
    push(8'h62);
    push(8'h63);
    rst = 1;
    in_valid = 1;
    in_data = 8'h99;
    out_ready = 1;
    tick();
    rst = 0;
    in_valid = 0;
    out_ready = 0;
    chk("mrst_count", 32'(count), 0);
    chk("mrst_valid", 32'(out_valid), 0);
    push(8'h7E);
    chk("mrst_first", 32'(out_data), 32'h7E);
    chk("mrst_valid2", 32'(out_valid), 1);
    drain_expect(8'h7E, "mrst_pop");

    // Randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (!in_valid || q.size() != D) begin
        in_valid = ($urandom_range(0, 99) < 60);
        in_data = 8'($urandom);
      end
      out_ready = ($urandom_range(0, 99) < ((c / 500) % 2 ? 75 : 40));
      tick();
    end
    rst = 0;
    in_valid = 0;
    out_ready = 1;
    repeat (6) tick();
    chk("end_empty", 32'(count), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
